// File: rtl/bus_access_sequencer.sv
// bus_access_sequencer
// Takes one read/write command at a time from a command master, drives the
// module address to the one-hot decoder, strobes the bus once the decoder
// has had a cycle to settle, waits for the addressed module's acknowledge
// (or a bounded timeout) and hands a single response back to the master.
//
// Handshake semantics (both the command and the response channel):
// a transfer happens on a rising CLK edge where VALID and READY are both 1.
// The producer holds VALID and its payload stable until that edge; the
// consumer may raise or lower READY freely. READY from the consumer is
// ignored while VALID is low.
module bus_access_sequencer #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic [2:0]            CMD_ADDR,
    input  logic                  CMD_WRITE,
    input  logic [DATA_W-1:0]     CMD_WDATA,
    output logic [2:0]            ADDR,
    output logic                  BUS_EN,
    output logic                  BUS_WE,
    output logic [DATA_W-1:0]     BUS_WDATA,
    input  logic [7:0]            BUS_ACK,
    input  logic [8*DATA_W-1:0]   BUS_RDATA,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [DATA_W-1:0]     RSP_RDATA,
    output logic                  RSP_ERR,
    output logic [1:0]            DBG_STATE
);

    // The counter only ever needs to reach TIMEOUT-1: the cycle that would
    // take it to TIMEOUT is the one that reports the timeout instead.
    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                cmd_ready_q;
    logic [2:0]          addr_q;
    logic                bus_en_q;
    logic                bus_we_q;
    logic [DATA_W-1:0]   bus_wdata_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;

    // Acknowledge and read data of the currently addressed module only;
    // every other module's ack is irrelevant to this transaction.
    logic                sel_ack;
    logic [DATA_W-1:0]   sel_rdata;

    assign sel_ack   = BUS_ACK[addr_q];
    assign sel_rdata = BUS_RDATA[addr_q*DATA_W +: DATA_W];

    // Transaction FSM; every output comes straight from a register here.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            addr_q      <= '0;
            bus_en_q    <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_ready_q && CMD_VALID) begin
                        addr_q      <= CMD_ADDR;
                        bus_we_q    <= CMD_WRITE;
                        bus_wdata_q <= CMD_WRITE ? CMD_WDATA : '0;
                        cmd_ready_q <= 1'b0;
                        state_q     <= ST_SETUP;
                    end else begin
                        // First idle edge after reset or a response raises READY.
                        cmd_ready_q <= 1'b1;
                    end
                end

                ST_SETUP: begin
                    // ADDR has been stable for one cycle; the decoder output is
                    // settled, so the strobe may now qualify it.
                    bus_en_q <= 1'b1;
                    cnt_q    <= '0;
                    state_q  <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    if (sel_ack) begin
                        rsp_rdata_q <= bus_we_q ? '0 : sel_rdata;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        bus_en_q    <= 1'b0;
                        bus_we_q    <= 1'b0;
                        state_q     <= ST_RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        // Last permitted cycle ended without an ack.
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        bus_en_q    <= 1'b0;
                        bus_we_q    <= 1'b0;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                ST_RESP: begin
                    if (RSP_READY) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign CMD_READY = cmd_ready_q;
    assign ADDR      = addr_q;
    assign BUS_EN    = bus_en_q;
    assign BUS_WE    = bus_we_q;
    assign BUS_WDATA = bus_wdata_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_RDATA = rsp_rdata_q;
    assign RSP_ERR   = rsp_err_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_bus_access_sequencer.sv
// tb_bus_access_sequencer
// Directed scenarios for bus_access_sequencer: reset, immediate read,
// delayed write, timeout boundary, foreign acks with response backpressure,
// reset abort and back-to-back throughput.
module tb_bus_access_sequencer;

    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 15;

    logic                CLK;
    logic                RST;
    logic                CMD_VALID;
    logic                CMD_READY;
    logic [2:0]          CMD_ADDR;
    logic                CMD_WRITE;
    logic [DATA_W-1:0]   CMD_WDATA;
    logic [2:0]          ADDR;
    logic                BUS_EN;
    logic                BUS_WE;
    logic [DATA_W-1:0]   BUS_WDATA;
    logic [7:0]          BUS_ACK;
    logic [8*DATA_W-1:0] BUS_RDATA;
    logic                RSP_VALID;
    logic                RSP_READY;
    logic [DATA_W-1:0]   RSP_RDATA;
    logic                RSP_ERR;
    logic [1:0]          DBG_STATE;

    int tests_run;
    int tests_failed;

    bus_access_sequencer #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_ADDR  (CMD_ADDR),
        .CMD_WRITE (CMD_WRITE),
        .CMD_WDATA (CMD_WDATA),
        .ADDR      (ADDR),
        .BUS_EN    (BUS_EN),
        .BUS_WE    (BUS_WE),
        .BUS_WDATA (BUS_WDATA),
        .BUS_ACK   (BUS_ACK),
        .BUS_RDATA (BUS_RDATA),
        .RSP_VALID (RSP_VALID),
        .RSP_READY (RSP_READY),
        .RSP_RDATA (RSP_RDATA),
        .RSP_ERR   (RSP_ERR),
        .DBG_STATE (DBG_STATE)
    );

    // Clock generation
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Advance one edge and settle past it before sampling/driving.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue_cmd(input logic [2:0] a, input logic w, input logic [7:0] d);
        CMD_VALID = 1'b1;
        CMD_ADDR  = a;
        CMD_WRITE = w;
        CMD_WDATA = d;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({CMD_READY, ADDR, BUS_EN, BUS_WE, BUS_WDATA, RSP_VALID, RSP_RDATA, RSP_ERR} !== 23'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h required 0",
                     {CMD_READY, ADDR, BUS_EN, BUS_WE, BUS_WDATA, RSP_VALID, RSP_RDATA, RSP_ERR});
        end
        tests_run++;
        if (DBG_STATE !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d required 0", DBG_STATE);
        end
        RST = 1'b0;
        tick();
        tests_run++;
        if (CMD_READY !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready_rise: got %b required 1", CMD_READY);
        end
    endtask

    task automatic test_read_immediate();
        RSP_READY = 1'b1;
        BUS_RDATA = '0;
        BUS_RDATA[3*8 +: 8] = 8'hA5;
        issue_cmd(3'd3, 1'b0, 8'hEE);
        tick(); // edge N: accept
        CMD_VALID = 1'b0;
        tests_run++;
        if ({CMD_READY, ADDR, BUS_EN} !== {1'b0, 3'd3, 1'b0}) begin
            tests_failed++;
            $display("FAIL rd_setup: got rdy=%b addr=%0d en=%b required 0/3/0", CMD_READY, ADDR, BUS_EN);
        end
        tick(); // edge N+1: into ACCESS
        tests_run++;
        if ({BUS_EN, BUS_WE, ADDR, BUS_WDATA, RSP_VALID} !== {1'b1, 1'b0, 3'd3, 8'h00, 1'b0}) begin
            tests_failed++;
            $display("FAIL rd_access: got en=%b we=%b addr=%0d wd=%h rv=%b required 1/0/3/00/0",
                     BUS_EN, BUS_WE, ADDR, BUS_WDATA, RSP_VALID);
        end
        BUS_ACK = 8'h08;
        tick(); // edge N+2: ack sampled
        BUS_ACK = 8'h00;
        tests_run++;
        if ({RSP_VALID, RSP_RDATA, RSP_ERR, BUS_EN} !== {1'b1, 8'hA5, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL rd_resp: got rv=%b rd=%h err=%b en=%b required 1/a5/0/0",
                     RSP_VALID, RSP_RDATA, RSP_ERR, BUS_EN);
        end
        tick(); // edge N+3: response taken
        tests_run++;
        if ({RSP_VALID, CMD_READY} !== 2'b01) begin
            tests_failed++;
            $display("FAIL rd_done: got rv=%b rdy=%b required 0/1", RSP_VALID, CMD_READY);
        end
    endtask

    task automatic test_write_delayed();
        RSP_READY = 1'b1;
        BUS_RDATA = '0;
        BUS_RDATA[7*8 +: 8] = 8'hFF;
        issue_cmd(3'd7, 1'b1, 8'h3C);
        tick();
        CMD_VALID = 1'b0;
        tick(); // first ACCESS cycle
        for (int i = 1; i <= 4; i++) begin
            tests_run++;
            if ({BUS_EN, BUS_WE, ADDR, BUS_WDATA, RSP_VALID} !== {1'b1, 1'b1, 3'd7, 8'h3C, 1'b0}) begin
                tests_failed++;
                $display("FAIL wr_hold_c%0d: got en=%b we=%b addr=%0d wd=%h rv=%b required 1/1/7/3c/0",
                         i, BUS_EN, BUS_WE, ADDR, BUS_WDATA, RSP_VALID);
            end
            if (i == 4) BUS_ACK = 8'h80;
            tick();
        end
        BUS_ACK = 8'h00;
        tests_run++;
        if ({RSP_VALID, RSP_RDATA, RSP_ERR, BUS_EN, BUS_WE} !== {1'b1, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL wr_resp: got rv=%b rd=%h err=%b en=%b we=%b required 1/00/0/0/0",
                     RSP_VALID, RSP_RDATA, RSP_ERR, BUS_EN, BUS_WE);
        end
        tick();
        tests_run++;
        if ({RSP_VALID, CMD_READY} !== 2'b01) begin
            tests_failed++;
            $display("FAIL wr_done: got rv=%b rdy=%b required 0/1", RSP_VALID, CMD_READY);
        end
    endtask

    task automatic test_timeout(input logic ack_on_last);
        int n;
        RSP_READY = 1'b1;
        BUS_RDATA = '0;
        BUS_RDATA[2*8 +: 8] = 8'h5A;
        issue_cmd(3'd2, 1'b0, 8'h00);
        tick();
        CMD_VALID = 1'b0;
        tick();
        n = 0;
        while (BUS_EN === 1'b1 && n < 40) begin
            n++;
            if (ack_on_last && n == TIMEOUT) BUS_ACK = 8'h04;
            tick();
        end
        BUS_ACK = 8'h00;
        tests_run++;
        if (n !== TIMEOUT) begin
            tests_failed++;
            $display("FAIL to_en_cycles(ack=%b): got %0d required %0d", ack_on_last, n, TIMEOUT);
        end
        tests_run++;
        if ({RSP_VALID, RSP_ERR, RSP_RDATA} !== {1'b1, ~ack_on_last, (ack_on_last ? 8'h5A : 8'h00)}) begin
            tests_failed++;
            $display("FAIL to_resp(ack=%b): got rv=%b err=%b rd=%h required 1/%b/%h", ack_on_last,
                     RSP_VALID, RSP_ERR, RSP_RDATA, ~ack_on_last, (ack_on_last ? 8'h5A : 8'h00));
        end
        tick();
        tests_run++;
        if ({RSP_VALID, CMD_READY} !== 2'b01) begin
            tests_failed++;
            $display("FAIL to_done(ack=%b): got rv=%b rdy=%b required 0/1", ack_on_last, RSP_VALID, CMD_READY);
        end
    endtask

    task automatic test_ignore_and_hold();
        int n;
        RSP_READY = 1'b0;
        BUS_RDATA = '0;
        BUS_RDATA[5*8 +: 8] = 8'hC3;
        BUS_RDATA[4*8 +: 8] = 8'h44;
        BUS_RDATA[6*8 +: 8] = 8'h66;
        issue_cmd(3'd5, 1'b0, 8'h00);
        tick();
        CMD_VALID = 1'b0;
        tick();
        n = 0;
        while (BUS_EN === 1'b1 && n < 40) begin
            n++;
            BUS_ACK = n[0] ? 8'h10 : 8'h40;
            tick();
        end
        tests_run++;
        if (n !== TIMEOUT) begin
            tests_failed++;
            $display("FAIL ign_en_cycles: got %0d required %0d", n, TIMEOUT);
        end
        // Late ack from the addressed module and a new command while held.
        BUS_ACK = 8'h20;
        issue_cmd(3'd1, 1'b1, 8'h99);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if ({RSP_VALID, RSP_ERR, RSP_RDATA, CMD_READY, ADDR, BUS_EN} !==
                {1'b1, 1'b1, 8'h00, 1'b0, 3'd5, 1'b0}) begin
                tests_failed++;
                $display("FAIL ign_hold_c%0d: got rv=%b err=%b rd=%h rdy=%b addr=%0d en=%b required 1/1/00/0/5/0",
                         i, RSP_VALID, RSP_ERR, RSP_RDATA, CMD_READY, ADDR, BUS_EN);
            end
            if (i < 3) tick();
        end
        CMD_VALID = 1'b0;
        BUS_ACK   = 8'h00;
        RSP_READY = 1'b1;
        tick();
        tests_run++;
        if ({RSP_VALID, CMD_READY, DBG_STATE} !== {1'b0, 1'b1, 2'd0}) begin
            tests_failed++;
            $display("FAIL ign_done: got rv=%b rdy=%b st=%0d required 0/1/0", RSP_VALID, CMD_READY, DBG_STATE);
        end
    endtask

    task automatic test_reset_abort();
        logic saw_rsp;
        logic saw_en;
        RSP_READY = 1'b1;
        BUS_RDATA = '0;
        BUS_RDATA[1*8 +: 8] = 8'h11;
        issue_cmd(3'd1, 1'b0, 8'h00);
        tick();
        CMD_VALID = 1'b0;
        tick(); // ACCESS cycle 1
        tick(); // ACCESS cycle 2
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tests_run++;
        if ({BUS_EN, RSP_VALID, CMD_READY} !== 3'b000) begin
            tests_failed++;
            $display("FAIL abort_edge: got en=%b rv=%b rdy=%b required 0/0/0", BUS_EN, RSP_VALID, CMD_READY);
        end
        BUS_ACK = 8'h02;
        tick();
        tests_run++;
        if (CMD_READY !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_ready: got %b required 1", CMD_READY);
        end
        saw_rsp = 1'b0;
        saw_en  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (RSP_VALID === 1'b1) saw_rsp = 1'b1;
            if (BUS_EN === 1'b1) saw_en = 1'b1;
        end
        BUS_ACK = 8'h00;
        tests_run++;
        if ({saw_rsp, saw_en} !== 2'b00) begin
            tests_failed++;
            $display("FAIL abort_no_rsp: got rsp=%b en=%b required 0/0", saw_rsp, saw_en);
        end
    endtask

    task automatic test_back_to_back();
        int accepts;
        int rsps;
        RSP_READY = 1'b1;
        BUS_ACK   = 8'hFF;
        BUS_RDATA = '0;
        BUS_RDATA[0 +: 8] = 8'h42;
        issue_cmd(3'd0, 1'b0, 8'h00);
        accepts = 0;
        rsps    = 0;
        for (int i = 0; i < 12; i++) begin
            if (CMD_READY === 1'b1) accepts++;
            tick();
            if (RSP_VALID === 1'b1) begin
                rsps++;
                tests_run++;
                if ({RSP_RDATA, RSP_ERR} !== {8'h42, 1'b0}) begin
                    tests_failed++;
                    $display("FAIL b2b_data_%0d: got rd=%h err=%b required 42/0", rsps, RSP_RDATA, RSP_ERR);
                end
            end
        end
        CMD_VALID = 1'b0;
        BUS_ACK   = 8'h00;
        tests_run++;
        if (accepts !== 3 || rsps !== 3) begin
            tests_failed++;
            $display("FAIL b2b_rate: got accepts=%0d rsps=%0d required 3/3", accepts, rsps);
        end
    endtask

    // Scenario sequence and final report
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        RST       = 1'b1;
        CMD_VALID = 1'b0;
        CMD_ADDR  = 3'd0;
        CMD_WRITE = 1'b0;
        CMD_WDATA = 8'h00;
        BUS_ACK   = 8'h00;
        BUS_RDATA = '0;
        RSP_READY = 1'b0;

        test_reset();
        test_read_immediate();
        test_write_delayed();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_ignore_and_hold();
        test_reset_abort();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bus_access_sequencer.md
Name: bus_access_sequencer

Overview:
Sequences single read/write transactions from a command master onto the 8-slot module bus. Drives the 3-bit ADDR that feeds the one-hot address decoder, qualifies the decoder's selection with a bus strobe, waits for the addressed module's acknowledge or a timeout, then returns a response. Sits directly upstream of the address decoder, between the command master and the decoder/module fabric.

Parameters:
DATA_W, 8, data width of write and read data.
TIMEOUT, 15, ACCESS cycles allowed for an acknowledge (>=1).

Ports:
CLK  input  1  clock; all logic on rising edge.
RST  input  1  synchronous reset, active-high.
CMD_VALID  input  1  command present.
CMD_READY  output  1  sequencer can accept a command.
CMD_ADDR  input  3  target module index 0..7.
CMD_WRITE  input  1  1=write, 0=read.
CMD_WDATA  input  DATA_W  write data.
ADDR  output  3  module address to the decoder.
BUS_EN  output  1  access strobe; qualifies the decoder's one-hot select.
BUS_WE  output  1  write enable during access.
BUS_WDATA  output  DATA_W  write data to modules.
BUS_ACK  input  8  per-module acknowledge; bit i from module i.
BUS_RDATA  input  8*DATA_W  per-module read data; module i at bits [i*DATA_W +: DATA_W].
RSP_VALID  output  1  response present.
RSP_READY  input  1  master accepts response.
RSP_RDATA  output  DATA_W  read data (0 for writes and errors).
RSP_ERR  output  1  1 = timeout, no acknowledge.

Behaviour:
- Reset: clock and reset ports are CLK and RST; one clock; reset is synchronous and active-high. On any edge with RST=1: state=IDLE, timeout counter=0, and all outputs 0 (CMD_READY, ADDR, BUS_EN, BUS_WE, BUS_WDATA, RSP_VALID, RSP_RDATA, RSP_ERR). CMD_READY rises on the first edge with RST=0.
- All outputs are registered.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: CMD_READY=1. On CMD_VALID&CMD_READY at edge N: latch CMD_ADDR->ADDR, CMD_WRITE->BUS_WE, CMD_WDATA (or 0 for reads)->BUS_WDATA; CMD_READY=0; go to SETUP. No acceptance in any other state.
- SETUP: exactly 1 cycle (cycle N+1) with ADDR stable and BUS_EN=0 so the decoder settles. Go to ACCESS and set BUS_EN=1 and counter=0.
- ACCESS: BUS_EN=1; ADDR, BUS_WE and BUS_WDATA are held constant. Each cycle, sample BUS_ACK[ADDR]:
  - If BUS_ACK[ADDR]=1: RSP_RDATA = read ? BUS_RDATA slice ADDR : 0, RSP_ERR=0. Go to RESP.
  - Otherwise, increment the counter. When the TIMEOUT-th ACCESS cycle passes with no ack: RSP_ERR=1, RSP_RDATA=0. Go to RESP.
  - An ack in the TIMEOUT-th cycle wins over the timeout.
  - BUS_ACK bits of non-addressed modules are ignored.
- RESP: BUS_EN=0 and BUS_WE=0 from the edge entering RESP. RSP_VALID=1, with RSP_RDATA and RSP_ERR held stable until RSP_VALID&RSP_READY. On that edge: RSP_VALID=0, go to IDLE, CMD_READY=1.
- Latency: with immediate ack and RSP_READY high, command accept at edge N, BUS_EN high N+2, RSP_VALID high N+3, minimum 4 cycles per transaction.
- Counter width: clog2(TIMEOUT+1); it does not wrap, and is cleared on entering ACCESS.
- Reset mid-operation (any state): abort with no response. BUS_EN drops at that edge. The transaction is lost; the master must reissue.
- A late ack arriving after the timeout or in RESP/IDLE is ignored.
- CMD_VALID is ignored while not in IDLE.
- RSP_READY is ignored while RSP_VALID=0.

Test Plan:
- Reset, then read module 3: CMD_ADDR=3, CMD_WRITE=0. Module 3 acks on the first ACCESS cycle with BUS_RDATA slice 3=8'hA5. Require ADDR=3 from N+1, BUS_EN=1 only at N+2, and RSP_VALID at N+3 with RSP_RDATA=8'hA5, RSP_ERR=0.
- Write 8'h3C to module 7, ack after 4 ACCESS cycles. Require BUS_WE=1 and BUS_WDATA=8'h3C held through all 4 cycles, then a response with RSP_RDATA=0, RSP_ERR=0.
- Read module 2 with no ack (TIMEOUT=15). Require BUS_EN high for exactly 15 cycles, then RSP_ERR=1, RSP_RDATA=0. Repeat with the ack on the 15th cycle and require RSP_ERR=0.
- Read module 5 while BUS_ACK[4] and BUS_ACK[6] pulse. Require them ignored and a timeout reported. Hold RSP_READY=0 for 3 cycles and require RSP_VALID and data stable, CMD_READY=0, and a new CMD_VALID not accepted.
- Assert RST for 1 cycle during ACCESS. Require BUS_EN=0 and RSP_VALID=0 after that edge, CMD_READY=1 on the following edge, and no response ever produced for the aborted command.
